// File: rtl/hdmi_pattern_sequencer_pkg.sv
// Shared types and helpers for the HDMI colour-bar bring-up sequencer.
// Holds the FSM state encoding, the pattern index width used by the
// display decoder, and small helper functions for counter sizing and
// pattern stepping.
package hdmi_pattern_sequencer_pkg;

  // Width of pattern_sel; the display decoder uses the same width.
  localparam int PATTERN_W = 3;

  // Sequencer states. Encoding 3 is unused and is treated as WAIT_LOCK.
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_WARMUP    = 2'd1,
    ST_RUN       = 2'd2
  } seq_state_e;

  // Counter width for a count range of n values, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next pattern index, wrapping num-1 back to 0.
  function automatic logic [PATTERN_W-1:0] next_pattern(
    input logic [PATTERN_W-1:0] sel,
    input int                   num
  );
    if (sel == PATTERN_W'(num - 1)) begin
      return {PATTERN_W{1'b0}};
    end else begin
      return sel + PATTERN_W'(1);
    end
  endfunction

endpackage

// File: rtl/hdmi_pattern_sequencer_if.sv
// Control bundle between the pattern sequencer and its surroundings:
// lock/key/vsync inputs towards the sequencer, transmitter reset,
// video enable and pattern select back out.
interface hdmi_pattern_sequencer_if;
  import hdmi_pattern_sequencer_pkg::*;

  logic                 clk_locked;
  logic                 key_next;
  logic                 auto_en;
  logic                 video_vs;
  logic                 tx_rst_n;
  logic                 video_en;
  logic [PATTERN_W-1:0] pattern_sel;
  logic [1:0]           seq_state;

  // Side that drives lock/key/vsync and consumes the sequencer outputs.
  modport master (
    output clk_locked,
    output key_next,
    output auto_en,
    output video_vs,
    input  tx_rst_n,
    input  video_en,
    input  pattern_sel,
    input  seq_state
  );

  // The sequencer itself.
  modport slave (
    input  clk_locked,
    input  key_next,
    input  auto_en,
    input  video_vs,
    output tx_rst_n,
    output video_en,
    output pattern_sel,
    output seq_state
  );

endinterface

// File: rtl/hdmi_pattern_sequencer_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising
// edge detector. The level output is the synchronised signal; the rise
// output is a one-cycle pulse when that synchronised level goes 0 -> 1.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronise din into clk and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~prev_r;

endmodule

// File: rtl/hdmi_pattern_sequencer.sv
// Bring-up sequencer for the HDMI colour-bar path (pixel_clk domain).
// Keeps the DVI transmitter in reset until PLL lock has been stable for
// LOCK_CYCLES, runs TMDS blank for WARMUP_FRAMES frames, then enables
// video and steps the pattern selector on a frame timer or key press.
// Every change is applied on a frame boundary so no frame is torn.
module hdmi_pattern_sequencer
  import hdmi_pattern_sequencer_pkg::*;
#(
  parameter int   LOCK_CYCLES   = 1024,
  parameter int   WARMUP_FRAMES = 4,
  parameter int   HOLD_FRAMES   = 120,
  parameter int   NUM_PATTERNS  = 8,
  parameter logic VS_ACTIVE     = 1'b1
) (
  input logic                      pixel_clk,
  input logic                      sys_rst_n,
  hdmi_pattern_sequencer_if.slave  bus
);

  localparam int LOCK_W = cnt_width(LOCK_CYCLES);
  localparam int FRM_W  = cnt_width(WARMUP_FRAMES);
  localparam int HOLD_W = cnt_width(HOLD_FRAMES);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(WARMUP_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  // Synchronised inputs.
  logic lock_s;
  logic lock_rise_s;
  logic key_level_s;
  logic key_rise_s;

  // Frame boundary detection.
  logic vs_r;
  logic vs_prev_r;
  logic frame_start_s;

  // Sequencer state, counters and registered outputs.
  seq_state_e           state_r;
  logic [LOCK_W-1:0]    lock_cnt_r;
  logic [FRM_W-1:0]     frm_cnt_r;
  logic [HOLD_W-1:0]    hold_cnt_r;
  logic                 key_pend_r;
  logic                 tx_rst_n_r;
  logic                 video_en_r;
  logic [PATTERN_W-1:0] pattern_sel_r;
  logic                 advance_s;

  sync_edge_det u_lock_sync (
    .clk   (pixel_clk),
    .rst_n (sys_rst_n),
    .din   (bus.clk_locked),
    .level (lock_s),
    .rise  (lock_rise_s)
  );

  sync_edge_det u_key_sync (
    .clk   (pixel_clk),
    .rst_n (sys_rst_n),
    .din   (bus.key_next),
    .level (key_level_s),
    .rise  (key_rise_s)
  );

  // Only the lock level and the key edge are used by the sequencer.
  logic unused_s;
  assign unused_s = lock_rise_s & key_level_s;

  // Register vsync and its previous value so the frame boundary is a clean pulse.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_r      <= ~VS_ACTIVE;
      vs_prev_r <= ~VS_ACTIVE;
    end else begin
      vs_r      <= bus.video_vs;
      vs_prev_r <= vs_r;
    end
  end

  assign frame_start_s = (vs_r == VS_ACTIVE) && (vs_prev_r != VS_ACTIVE);

  // A pending key (including one arriving on this very cycle) or an expired hold time steps the pattern.
  assign advance_s = key_pend_r || key_rise_s ||
                     (bus.auto_en && (hold_cnt_r == HOLD_LAST));

  // Sequencer FSM with its counters; lock loss overrides every state.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= ST_WAIT_LOCK;
      lock_cnt_r    <= {LOCK_W{1'b0}};
      frm_cnt_r     <= {FRM_W{1'b0}};
      hold_cnt_r    <= {HOLD_W{1'b0}};
      key_pend_r    <= 1'b0;
      tx_rst_n_r    <= 1'b0;
      video_en_r    <= 1'b0;
      pattern_sel_r <= {PATTERN_W{1'b0}};
    end else if (!lock_s) begin
      // Lost lock: restart bring-up but remember which pattern was on screen.
      state_r    <= ST_WAIT_LOCK;
      lock_cnt_r <= {LOCK_W{1'b0}};
      frm_cnt_r  <= {FRM_W{1'b0}};
      key_pend_r <= 1'b0;
      tx_rst_n_r <= 1'b0;
      video_en_r <= 1'b0;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          tx_rst_n_r <= 1'b0;
          video_en_r <= 1'b0;
          key_pend_r <= 1'b0;
          if (lock_cnt_r == LOCK_LAST) begin
            state_r    <= ST_WARMUP;
            lock_cnt_r <= {LOCK_W{1'b0}};
            tx_rst_n_r <= 1'b1;
          end else begin
            lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
          end
        end
        ST_WARMUP: begin
          tx_rst_n_r <= 1'b1;
          video_en_r <= 1'b0;
          key_pend_r <= 1'b0;
          if (frame_start_s) begin
            if (frm_cnt_r == FRM_LAST) begin
              // Enable on the boundary so the first visible frame is whole.
              state_r    <= ST_RUN;
              frm_cnt_r  <= {FRM_W{1'b0}};
              video_en_r <= 1'b1;
            end else begin
              frm_cnt_r <= frm_cnt_r + FRM_W'(1);
            end
          end else begin
            frm_cnt_r <= frm_cnt_r;
          end
        end
        ST_RUN: begin
          tx_rst_n_r <= 1'b1;
          video_en_r <= 1'b1;
          if (frame_start_s) begin
            if (advance_s) begin
              pattern_sel_r <= next_pattern(pattern_sel_r, NUM_PATTERNS);
              hold_cnt_r    <= {HOLD_W{1'b0}};
              key_pend_r    <= 1'b0;
            end else if (hold_cnt_r != HOLD_LAST) begin
              hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
              hold_cnt_r <= hold_cnt_r;
            end
          end else if (key_rise_s) begin
            // Further presses before the boundary collapse into one step.
            key_pend_r <= 1'b1;
          end else begin
            key_pend_r <= key_pend_r;
          end
        end
        default: begin
          state_r    <= ST_WAIT_LOCK;
          lock_cnt_r <= {LOCK_W{1'b0}};
          frm_cnt_r  <= {FRM_W{1'b0}};
          key_pend_r <= 1'b0;
          tx_rst_n_r <= 1'b0;
          video_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_rst_n    = tx_rst_n_r;
  assign bus.video_en    = video_en_r;
  assign bus.pattern_sel = pattern_sel_r;
  assign bus.seq_state   = state_r;

endmodule

// File: tb/tb_hdmi_pattern_sequencer.sv
// Self-checking bench for hdmi_pattern_sequencer. A behavioural model
// tracks input history (sync delay, vsync edges, key edges) and bring-up
// progress with plain integers; DUT outputs are compared every cycle plus
// directed checks for lock glitches, auto/key stepping and lock loss.
module tb_hdmi_pattern_sequencer;

  localparam int LOCK_CYCLES   = 16;
  localparam int WARMUP_FRAMES = 2;
  localparam int HOLD_FRAMES   = 3;
  localparam int NUM_PATTERNS  = 4;
  localparam int FRAME_LEN     = 100;
  localparam int VS_LEN        = 5;

  logic pixel_clk = 1'b0;
  logic sys_rst_n;
  logic lock_in, key_in, auto_in, vs_in;

  hdmi_pattern_sequencer_if bus ();

  assign bus.clk_locked = lock_in;
  assign bus.key_next   = key_in;
  assign bus.auto_en    = auto_in;
  assign bus.video_vs   = vs_in;

  hdmi_pattern_sequencer #(
    .LOCK_CYCLES   (LOCK_CYCLES),
    .WARMUP_FRAMES (WARMUP_FRAMES),
    .HOLD_FRAMES   (HOLD_FRAMES),
    .NUM_PATTERNS  (NUM_PATTERNS),
    .VS_ACTIVE     (1'b1)
  ) dut (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int pix_cnt = 0;

  // Reference model: phase 0 = waiting for lock, 1 = warm-up, 2 = running.
  int m_phase, m_stable, m_frames, m_since, m_pattern;
  bit m_pending;
  bit lock_h [3];
  bit key_h  [3];
  bit vs_h   [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_stable = 0; m_frames = 0; m_since = 0; m_pattern = 0; m_pending = 0;
    for (int i = 0; i < 3; i++) begin lock_h[i] = 0; key_h[i] = 0; end
    vs_h[0] = 0; vs_h[1] = 0;
  endtask

  // One clock edge of the reference model, using what the inputs were at earlier edges.
  task automatic model_step();
    bit lk, kp, fs;
    lk = lock_h[1];                    // lock as seen through two sync stages
    kp = key_h[1] && !key_h[2];        // key rising edge after synchronisation
    fs = vs_h[0] && !vs_h[1];          // vsync became active one edge ago
    if (!lk) begin
      m_phase = 0; m_stable = 0; m_frames = 0; m_pending = 0;
    end else if (m_phase == 0) begin
      m_stable++;
      if (m_stable == LOCK_CYCLES) begin m_phase = 1; m_stable = 0; end
    end else if (m_phase == 1) begin
      if (fs) m_frames++;
      if (m_frames == WARMUP_FRAMES) begin m_phase = 2; m_frames = 0; end
    end else begin
      if (fs) begin
        if (m_pending || kp || (auto_in && m_since >= HOLD_FRAMES - 1)) begin
          m_pattern = (m_pattern + 1) % NUM_PATTERNS;
          m_since = 0;
          m_pending = 0;
        end else if (m_since < HOLD_FRAMES - 1) begin
          m_since++;
        end
      end else if (kp) begin
        m_pending = 1;
      end
    end
    lock_h[2] = lock_h[1]; lock_h[1] = lock_h[0]; lock_h[0] = lock_in;
    key_h[2]  = key_h[1];  key_h[1]  = key_h[0];  key_h[0]  = key_in;
    vs_h[1]   = vs_h[0];   vs_h[0]   = vs_in;
  endtask

  task automatic check_outputs(input string sfx);
    check({"tx_rst_n", sfx},    bus.tx_rst_n,    8'(m_phase != 0));
    check({"video_en", sfx},    bus.video_en,    8'(m_phase == 2));
    check({"pattern_sel", sfx}, bus.pattern_sel, 8'(m_pattern));
    check({"seq_state", sfx},   bus.seq_state,   8'(m_phase));
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    edge_no++;
    if (!sys_rst_n) model_reset(); else model_step();
    #1;
    check_outputs("");
    pix_cnt = (pix_cnt + 1) % FRAME_LEN;
    vs_in   = (pix_cnt < VS_LEN);
  endtask

  task automatic wait_pix(input int p);
    int n = 0;
    while (pix_cnt != p && n < 2 * FRAME_LEN) begin tick(); n++; end
    check("wait_pix", 8'(pix_cnt), 8'(p));
  endtask

  task automatic press_key();
    key_in = 1'b1; repeat (4) tick();
    key_in = 1'b0; repeat (4) tick();
  endtask

  int lock_edge, relock_edge, rise_edge, n, p0, glitch_left;
  int chg_val [4];
  int chg_edge[4];
  int nchg;
  logic [2:0] last_sel;

  initial begin
    sys_rst_n = 1'b0; lock_in = 1'b0; key_in = 1'b0; auto_in = 1'b0;
    vs_in = 1'b1; glitch_left = 0;
    model_reset();
    repeat (3) tick();
    check("reset_tx_rst_n", bus.tx_rst_n, 8'd0);
    check("reset_state",    bus.seq_state, 8'd0);
    sys_rst_n = 1'b1;
    repeat (5) tick();

    // Lock rises, glitches at lock_cnt=10, then the full count restarts.
    lock_in = 1'b1; lock_edge = edge_no + 1;
    repeat (12) tick();
    lock_in = 1'b0; tick();
    lock_in = 1'b1; relock_edge = edge_no + 1;
    rise_edge = 0; n = 0;
    while (bus.tx_rst_n !== 1'b1 && n < 60) begin tick(); n++; end
    if (bus.tx_rst_n === 1'b1) rise_edge = edge_no;
    check("tx_release_latency", 8'(rise_edge - relock_edge + 1), 8'd18);
    check("no_early_release", 8'(rise_edge > lock_edge + 17), 8'd1);

    // Warm-up frames, then video enabled on pattern 0.
    n = 0;
    while (bus.video_en !== 1'b1 && n < 400) begin tick(); n++; end
    check("video_en_rise", bus.video_en, 8'd1);
    check("first_pattern", bus.pattern_sel, 8'd0);

    // Auto mode: 1,2,3,0 spaced HOLD_FRAMES frames apart.
    auto_in = 1'b1; nchg = 0; last_sel = bus.pattern_sel;
    for (int i = 0; i < 1250; i++) begin
      tick();
      if (bus.pattern_sel !== last_sel && nchg < 4) begin
        chg_val[nchg] = int'(bus.pattern_sel); chg_edge[nchg] = edge_no; nchg++;
      end
      last_sel = bus.pattern_sel;
    end
    check("auto_changes", 8'(nchg), 8'd4);
    for (int i = 0; i < 4; i++) check("auto_value", 8'(chg_val[i]), 8'((i + 1) % NUM_PATTERNS));
    for (int i = 1; i < 4; i++) check("auto_spacing", 8'(chg_edge[i] - chg_edge[i-1]),
                                      8'(HOLD_FRAMES * FRAME_LEN));

    // Key only: two presses in one frame give one step; a key on the boundary steps there.
    auto_in = 1'b0;
    wait_pix(30);
    p0 = int'(bus.pattern_sel);
    press_key(); press_key();
    check("key_waits_boundary", bus.pattern_sel, 8'(p0));
    wait_pix(20);
    check("key_single_step", bus.pattern_sel, 8'((p0 + 1) % NUM_PATTERNS));
    wait_pix(99);
    key_in = 1'b1;
    repeat (3) tick();
    check("key_on_frame_start", bus.pattern_sel, 8'((p0 + 2) % NUM_PATTERNS));
    key_in = 1'b0;
    repeat (120) tick();
    check("key_no_late_step", bus.pattern_sel, 8'((p0 + 2) % NUM_PATTERNS));

    // Auto and key in the same frame: one step, hold restarts.
    auto_in = 1'b1; n = 0;
    while (!(m_since == HOLD_FRAMES - 1 && pix_cnt == 30) && n < 500) begin tick(); n++; end
    p0 = int'(bus.pattern_sel);
    press_key();
    wait_pix(20);
    check("auto_key_single", bus.pattern_sel, 8'((p0 + 1) % NUM_PATTERNS));
    repeat (2 * FRAME_LEN) tick();
    check("hold_restart_hold", bus.pattern_sel, 8'((p0 + 1) % NUM_PATTERNS));
    repeat (FRAME_LEN) tick();
    check("hold_restart_step", bus.pattern_sel, 8'((p0 + 2) % NUM_PATTERNS));

    // Lock loss at pattern 2 and relock resumes on pattern 2.
    auto_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.pattern_sel !== 3'd2) begin wait_pix(30); press_key(); wait_pix(20); end
    end
    check("reach_pattern2", bus.pattern_sel, 8'd2);
    lock_in = 1'b0;
    repeat (3) tick();
    check("lockloss_tx", bus.tx_rst_n, 8'd0);
    check("lockloss_en", bus.video_en, 8'd0);
    repeat (10) tick();
    lock_in = 1'b1; n = 0;
    while (bus.video_en !== 1'b1 && n < 500) begin tick(); n++; end
    check("relock_en", bus.video_en, 8'd1);
    check("relock_pattern", bus.pattern_sel, 8'd2);

    // Randomised lock glitches, key presses and auto toggling against the model.
    for (int i = 0; i < 4000; i++) begin
      if (glitch_left > 0) begin
        glitch_left--;
        if (glitch_left == 0) lock_in = 1'b1;
      end else if ($urandom_range(599, 0) == 0) begin
        lock_in = 1'b0; glitch_left = $urandom_range(20, 1);
      end
      if ($urandom_range(29, 0) == 0) key_in = ~key_in;
      if ($urandom_range(299, 0) == 0) auto_in = ~auto_in;
      tick();
    end

    // Asynchronous reset in the middle of warm-up, with no clock edge.
    key_in = 1'b0; lock_in = 1'b0;
    repeat (5) tick();
    lock_in = 1'b1; n = 0;
    while (m_phase != 1 && n < 100) begin tick(); n++; end
    check("warmup_reached", bus.seq_state, 8'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("_async_reset");
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
